crossbar_group_scheduler: RTL and testbench
===========================================

Name: crossbar_group_scheduler

Overview:
- Arbitration and configuration controller for the 16x16 group-level crossbar stage and its per-group 1x4 fan-out stage.
- Accepts packet requests from the 16 special L1 sources (SM inputs 48..63), each addressed to one of 64 destination SMs.
- Runs one round-robin arbiter per destination group and holds each grant for a whole packet.
- Drives the registered 4-bit group selects and 2-bit within-group selects, with per-source valid/ready handshakes.

Parameters:
NUM_SRC, 16, number of requesting sources; also the number of destination groups (fixed 16 in this version).
HOLD_MAX, 8, maximum beats one grant may carry before forced re-arbitration (1..255).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset; asynchronous, active-low.
req_valid  input  16  source s presents a beat.
req_dst  input  96  6 bits per source (s*6 +: 6): [5:2] destination group, [1:0] SM within group.
req_last  input  16  current beat of source s is the last beat of its packet.
req_ready  output  16  beat of source s is accepted this cycle.
sel_sm_to_group  output  64  4 bits per group (g*4 +: 4): source index routed to group g.
sel_group_to_sm  output  32  2 bits per group (g*2 +: 2): SM within group g that receives the data.
grp_valid  output  16  group g carries a valid beat this cycle.
grp_busy  output  16  group g is owned by a source.

Behaviour:
- Reset values (rst low, async): all groups IDLE; rr pointers 0; beat counters 0; sel_sm_to_group 0; sel_group_to_sm 0; req_ready 0; grp_valid 0; grp_busy 0.
- Per-group FSM, two states: IDLE and BUSY. Registered state: owner[3:0], dsm[1:0], beat_cnt[7:0], rr[3:0].
- IDLE, candidates: sources s with req_valid[s]=1, req_dst[s][5:2]=g, and s not the owner of any BUSY group.
- IDLE, selection: winner is the first candidate at index rr, rr+1, ... wrapping 15->0.
- IDLE with a winner: next cycle BUSY; owner <= winner; dsm <= req_dst[winner][1:0]; beat_cnt <= 0; sel_sm_to_group[g] <= winner; sel_group_to_sm[g] <= dsm. No candidate: remain IDLE; selects hold their last value.
- A source has a single destination at a time, so it is a candidate for at most one group. No cross-group conflict exists.
- BUSY outputs:
  - req_ready[owner] = 1, combinational; independent of req_valid.
  - grp_valid[g] = req_valid[owner]; grp_busy[g] = 1.
  - A beat transfers when req_valid & req_ready.
- BUSY, per transfer: beat_cnt increments.
- BUSY release: on a transfer with req_last=1, or on the transfer where beat_cnt+1 == HOLD_MAX, go IDLE next cycle and set rr <= owner+1 (mod 16).
- Latency: request first visible in cycle N (group IDLE) -> req_ready high and first beat accepted in cycle N+1.
- One bubble cycle (IDLE) between consecutive grants of the same group.
- While BUSY, req_dst of the owner is ignored; owner and dsm stay latched until release. A packet continues to its intended SM even if req_dst changes.
- Owner drops req_valid while BUSY: group stays BUSY with grp_valid=0. There is no timeout.
- HOLD_MAX truncation: the remaining beats of the packet re-arbitrate as a new request. Other pending sources for that group win first via rr. With no competitor, the same source is re-granted after the one-cycle bubble.
- req_ready is 0 for any source that is not a current owner.
- A source's req_ready is never high for two groups at once.
- Reset asserted mid-packet: immediate return to reset values. The in-flight packet is dropped; no beat is accepted while rst is low.
- On rst deassertion, arbitration resumes on the next rising edge.

Test Plan:
- Single source: src 3 sends a 4-beat packet to dst 0x25 (group 9, SM 1) -> grp_busy[9] rises the cycle after req_valid; sel_sm_to_group[9]=3; sel_group_to_sm[9]=1; req_ready[3] high for 4 transfers; group IDLE one cycle after the last beat; rr[9]=4.
- Contention: srcs 2, 5, 14 each send 1-beat packets to group 0 continuously -> grants in order 2, 5, 14, 2; one IDLE bubble between each; losers' req_ready stays 0.
- Wrap-around: rr[7]=15 with srcs 0 and 15 requesting group 7 -> 15 granted first, then 0; rr ends at 1.
- HOLD_MAX: src 6 sends a 20-beat packet to group 4 with HOLD_MAX=8 and no competitor -> grants of 8, 8, 4 beats with one bubble each. Same test with src 9 also requesting -> 8 beats of src 6, then src 9's packet, then src 6 resumes.
- Stall and dst change: owner drops req_valid for 3 cycles mid-packet and changes req_dst -> grp_busy stays 1, grp_valid 0 for 3 cycles, selects unchanged, remaining beats go to the latched SM.
- Reset mid-op: rst low during beat 2 of 5 -> all outputs 0 within the same cycle (async). After release, the re-presented request is granted one cycle later with rr=0.

Source files
------------

// File: rtl/crossbar_group_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : crossbar_group_scheduler
// Purpose  : Arbitration and configuration controller for the 16x16
//            group-level crossbar and the per-group 1x4 fan-out stage.
//            One round-robin arbiter per destination group; a grant is held
//            for a whole packet (or HOLD_MAX beats, whichever comes first).
// Ports    : clk             - clock, rising edge
//            rst             - asynchronous reset, active low
//            req_valid[s]    - source s presents a beat
//            req_dst[s*6+:6] - [5:2] destination group, [1:0] SM in group
//            req_last[s]     - current beat is the last of the packet
//            req_ready[s]    - beat of source s accepted this cycle
//            sel_sm_to_group - 4 bits per group: source routed to group g
//            sel_group_to_sm - 2 bits per group: SM in group g receiving data
//            grp_valid[g]    - group g carries a valid beat this cycle
//            grp_busy[g]     - group g is owned by a source
// Revision : 1.0  initial release
// ============================================================================
module crossbar_group_scheduler #(
    parameter int NUM_SRC  = 16,
    parameter int HOLD_MAX = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_SRC-1:0]     req_valid,
    input  logic [NUM_SRC*6-1:0]   req_dst,
    input  logic [NUM_SRC-1:0]     req_last,
    output logic [NUM_SRC-1:0]     req_ready,
    output logic [NUM_SRC*4-1:0]   sel_sm_to_group,
    output logic [NUM_SRC*2-1:0]   sel_group_to_sm,
    output logic [NUM_SRC-1:0]     grp_valid,
    output logic [NUM_SRC-1:0]     grp_busy
);

    // Source count and group count are the same fixed 16 in this version.
    localparam int         c_NUM_GRP = NUM_SRC;
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_BUSY   = 1'b1;

    logic [5:0]             w_dst [c_NUM_GRP];
    logic [c_NUM_GRP-1:0]   w_busy;
    logic [c_NUM_GRP*4-1:0] w_owner_flat;
    logic [NUM_SRC-1:0]     w_owned;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_dst
        assign w_dst[s] = req_dst[s*6 +: 6];
    end

    // A source owning any BUSY group is excluded from arbitration everywhere,
    // and that ownership is exactly what drives its ready.
    always_comb begin
        w_owned = '0;
        for (int g = 0; g < c_NUM_GRP; g++) begin
            if (w_busy[g]) begin
                w_owned[w_owner_flat[g*4 +: 4]] = 1'b1;
            end
        end
    end

    assign req_ready = w_owned;

    for (genvar g = 0; g < c_NUM_GRP; g++) begin : g_grp
        logic [0:0]  r_state;
        logic [3:0]  r_owner;     // also the registered group select
        logic [1:0]  r_dsm;       // also the registered within-group select
        logic [7:0]  r_beat_cnt;
        logic [3:0]  r_rr;

        logic [15:0] w_cand;
        logic        w_found;
        logic [3:0]  w_win;
        logic [3:0]  w_idx;
        logic        w_xfer;
        logic        w_release;
        logic [8:0]  w_cnt_inc;

        always_comb begin
            w_cand = '0;
            for (int s = 0; s < NUM_SRC; s++) begin
                w_cand[s] = req_valid[s] && (w_dst[s][5:2] == 4'(g)) && !w_owned[s];
            end
            // Scan starting at the round-robin pointer, wrapping 15 -> 0.
            w_found = 1'b0;
            w_win   = r_rr;
            w_idx   = r_rr;
            for (int i = 0; i < 16; i++) begin
                w_idx = r_rr + 4'(i);
                if (!w_found && w_cand[w_idx]) begin
                    w_found = 1'b1;
                    w_win   = w_idx;
                end
            end
        end

        assign w_xfer    = (r_state == ST_BUSY) && req_valid[r_owner];
        assign w_cnt_inc = {1'b0, r_beat_cnt} + 9'd1;
        assign w_release = w_xfer && (req_last[r_owner] || (w_cnt_inc == 9'(HOLD_MAX)));

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_state    <= ST_IDLE;
                r_owner    <= 4'd0;
                r_dsm      <= 2'd0;
                r_beat_cnt <= 8'd0;
                r_rr       <= 4'd0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_found) begin
                            r_state    <= ST_BUSY;
                            r_owner    <= w_win;
                            r_dsm      <= w_dst[w_win][1:0];
                            r_beat_cnt <= 8'd0;
                        end
                    end
                    ST_BUSY: begin
                        if (w_release) begin
                            // Owner and dsm hold so the selects keep their value.
                            r_state    <= ST_IDLE;
                            r_rr       <= r_owner + 4'd1;
                            r_beat_cnt <= 8'd0;
                        end else if (w_xfer) begin
                            r_beat_cnt <= w_cnt_inc[7:0];
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end

        assign w_busy[g]                = (r_state == ST_BUSY);
        assign w_owner_flat[g*4 +: 4]   = r_owner;
        assign sel_sm_to_group[g*4 +: 4] = r_owner;
        assign sel_group_to_sm[g*2 +: 2] = r_dsm;
        assign grp_busy[g]              = w_busy[g];
        assign grp_valid[g]             = w_busy[g] && req_valid[r_owner];
    end

endmodule
`default_nettype wire

// File: tb/tb_crossbar_group_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_crossbar_group_scheduler
// Purpose  : Self-checking bench for crossbar_group_scheduler. A behavioural
//            source model issues packets; expected beats {group,src,sm} are
//            queued when a packet is issued and a monitor pops them whenever
//            a group shows a valid beat.
// Revision : 1.0  initial release
// ============================================================================
module tb_crossbar_group_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] req_valid;
    logic [95:0] req_dst;
    logic [15:0] req_last;
    logic [15:0] req_ready;
    logic [63:0] sel_sm_to_group;
    logic [31:0] sel_group_to_sm;
    logic [15:0] grp_valid;
    logic [15:0] grp_busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [9:0] sb_q [$];

    int         src_rem   [16];
    int         src_len   [16];
    int         src_pos   [16];
    logic [5:0] src_dst   [16];
    bit         src_stall [16];

    crossbar_group_scheduler #(.NUM_SRC(16), .HOLD_MAX(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_dst         (req_dst),
        .req_last        (req_last),
        .req_ready       (req_ready),
        .sel_sm_to_group (sel_sm_to_group),
        .sel_group_to_sm (sel_group_to_sm),
        .grp_valid       (grp_valid),
        .grp_busy        (grp_busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_valid = '0;
        req_last  = '0;
        req_dst   = '0;
        for (int s = 0; s < 16; s++) begin
            req_valid[s]      = (src_rem[s] > 0) && !src_stall[s];
            req_last[s]       = (src_pos[s] == src_len[s] - 1);
            req_dst[s*6 +: 6] = src_dst[s];
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start(input int s, input logic [5:0] dst, input int len, input int total);
        src_dst[s]   = dst;
        src_len[s]   = len;
        src_pos[s]   = 0;
        src_rem[s]   = total;
        src_stall[s] = 1'b0;
    endtask

    task automatic push(input int g, input int s, input int sm, input int n);
        for (int i = 0; i < n; i++) sb_q.push_back({4'(g), 4'(s), 2'(sm)});
    endtask

    function automatic bit any_rem();
        for (int s = 0; s < 16; s++) if (src_rem[s] > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || any_rem()) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(n < 1000), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    // Source model: a beat fired if valid & ready were high just before the
    // edge; no beat moves while reset is held.
    initial begin
        logic [15:0] fire;
        forever begin
            @(negedge clk);
            fire = req_valid & req_ready;
            @(posedge clk);
            #1;
            if (rst) begin
                for (int s = 0; s < 16; s++) begin
                    if (fire[s]) begin
                        src_rem[s]--;
                        src_pos[s] = (src_pos[s] + 1 == src_len[s]) ? 0 : src_pos[s] + 1;
                    end
                end
            end
        end
    end

    // Monitor: every valid group beat must match the next queued expectation.
    initial begin
        logic [15:0] seen;
        logic [3:0]  s;
        logic [9:0]  got;
        logic [9:0]  e;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = '0;
                for (int g = 0; g < 16; g++) begin
                    if (grp_valid[g]) begin
                        s    = sel_sm_to_group[g*4 +: 4];
                        got  = {4'(g), s, sel_group_to_sm[g*2 +: 2]};
                        seen[s] = 1'b1;
                        if (sb_q.size() == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL sb_extra: got beat 0x%0h, expected none", got);
                        end else begin
                            e = sb_q.pop_front();
                            check("sb_beat", 32'(got), 32'(e));
                        end
                    end
                end
                check("xfer_vs_grp", 32'(req_valid & req_ready), 32'(seen));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] busy_bits;
        for (int s = 0; s < 16; s++) begin
            src_rem[s] = 0; src_len[s] = 1; src_pos[s] = 0;
            src_dst[s] = 6'd0; src_stall[s] = 1'b0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_busy",  32'(grp_busy), 32'h0);
        check("rst_valid", 32'(grp_valid), 32'h0);
        check("rst_sel_g", sel_sm_to_group[31:0], 32'h0);
        check("rst_sel_m", sel_group_to_sm, 32'h0);
        tick();
        rst = 1'b1;

        // Single source: src 3, 4 beats to dst 0x25 (group 9, SM 1)
        tick();
        start(3, 6'h25, 4, 4);
        push(9, 3, 1, 4);
        @(negedge clk);
        check("t1_busy_c0", 32'(grp_busy), 32'h0);
        @(negedge clk);
        check("t1_busy_c1", 32'(grp_busy), 32'h0200);
        check("t1_sel_g",   32'(sel_sm_to_group[36 +: 4]), 32'd3);
        check("t1_sel_m",   32'(sel_group_to_sm[18 +: 2]), 32'd1);
        check("t1_ready",   32'(req_ready), 32'h0008);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t1_ready_hold", 32'(req_ready), 32'h0008);
        end
        @(negedge clk);
        check("t1_idle", 32'(grp_busy), 32'h0);
        wait_done("t1_done");

        // Contention: 2, 5, 14 to group 0, two 1-beat packets each
        tick();
        start(2, 6'h01, 1, 2);
        start(5, 6'h02, 1, 2);
        start(14, 6'h03, 1, 2);
        push(0, 2, 1, 1); push(0, 5, 2, 1); push(0, 14, 3, 1);
        push(0, 2, 1, 1); push(0, 5, 2, 1); push(0, 14, 3, 1);
        busy_bits = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            busy_bits[k] = grp_busy[0];
            if (k == 1) check("t2_ready_a", 32'(req_ready), 32'h0004);
            if (k == 3) check("t2_ready_b", 32'(req_ready), 32'h0020);
            if (k == 5) check("t2_ready_c", 32'(req_ready), 32'h4000);
            if (k == 7) check("t2_ready_d", 32'(req_ready), 32'h0004);
            if (k == 2 || k == 4 || k == 6) check("t2_bubble_ready", 32'(req_ready), 32'h0);
        end
        check("t2_busy_pattern", 32'(busy_bits[7:0]), 32'hAA);
        wait_done("t2_done");

        // Wrap-around: push rr[7] to 15, then 15 beats 0, then rr=1 picks 1 over 0
        tick();
        start(14, 6'h1C, 1, 1);
        push(7, 14, 0, 1);
        wait_done("t3a_done");
        tick();
        start(0, 6'h1C, 1, 1);
        start(15, 6'h1D, 1, 1);
        push(7, 15, 1, 1); push(7, 0, 0, 1);
        wait_done("t3b_done");
        tick();
        start(0, 6'h1E, 1, 1);
        start(1, 6'h1F, 1, 1);
        push(7, 1, 3, 1); push(7, 0, 2, 1);
        wait_done("t3c_done");

        // HOLD_MAX: src 6, 20-beat packet, no competitor -> 8, 8, 4 with bubbles
        tick();
        start(6, 6'h10, 20, 20);
        push(4, 6, 0, 20);
        busy_bits = '0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            busy_bits[k] = grp_busy[4];
        end
        check("t4_segments", 32'(busy_bits), 32'h7BFDFE);
        wait_done("t4_done");

        // HOLD_MAX with competitor src 9 arriving one cycle later
        tick();
        start(6, 6'h10, 20, 20);
        tick();
        start(9, 6'h13, 3, 3);
        push(4, 6, 0, 8); push(4, 9, 3, 3); push(4, 6, 0, 12);
        wait_done("t4b_done");

        // Stall and dst change: src 10, 6 beats to 0x2E (group 11, SM 2)
        tick();
        start(10, 6'h2E, 6, 6);
        push(11, 10, 2, 6);
        tick();
        tick();
        tick();
        src_stall[10] = 1'b1;
        src_dst[10]   = 6'h05;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t5_busy",  32'(grp_busy), 32'h0800);
            check("t5_valid", 32'(grp_valid), 32'h0);
            check("t5_sel_g", 32'(sel_sm_to_group[44 +: 4]), 32'd10);
            check("t5_sel_m", 32'(sel_group_to_sm[22 +: 2]), 32'd2);
            tick();
        end
        src_stall[10] = 1'b0;
        wait_done("t5_done");

        // Reset mid-packet: rr[14] first moved to 14 by src 13
        tick();
        start(13, 6'h38, 1, 1);
        push(14, 13, 0, 1);
        wait_done("t6a_done");
        tick();
        start(12, 6'h3B, 5, 5);
        push(14, 12, 3, 1);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("t6_rst_ready", 32'(req_ready), 32'h0);
        check("t6_rst_busy",  32'(grp_busy), 32'h0);
        check("t6_rst_valid", 32'(grp_valid), 32'h0);
        check("t6_rst_sel_g", sel_sm_to_group[63:32], 32'h0);
        check("t6_rst_sel_m", sel_group_to_sm, 32'h0);
        src_rem[12] = 0;
        tick();
        start(12, 6'h3B, 5, 5);
        start(13, 6'h38, 1, 1);
        push(14, 12, 3, 5); push(14, 13, 0, 1);
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("t6_rel_c0", 32'(grp_busy), 32'h0);
        @(negedge clk);
        check("t6_rel_c1",  32'(grp_busy), 32'h4000);
        check("t6_rel_sel", 32'(sel_sm_to_group[56 +: 4]), 32'd12);
        wait_done("t6_done");

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
